// File: rtl/mmu_monitor_pkg.sv
// Shared state encodings, parameter defaults and sizing helper for the replica-path timing monitor.
package mmu_monitor_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WARMUP  = 2'd1;
    localparam logic [1:0] ST_MONITOR = 2'd2;
    localparam logic [1:0] ST_ALERT   = 2'd3;

    localparam int unsigned DEF_WARMUP_CYCLES = 4;
    localparam int unsigned DEF_ERR_THRESH    = 3;
    localparam int unsigned DEF_CNT_W         = 16;

    // Number of bits needed to hold values 0..maxval (at least 1).
    function automatic int unsigned cnt_width(input int unsigned maxval);
        int unsigned w;
        w = 1;
        while ((maxval >> w) != 0) w++;
        return w;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at MAX; clear has priority over increment.
module sat_counter #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] MAX   = '1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_o <= '0;
        end else if (clr_i) begin
            count_o <= '0;
        end else if (inc_i && (count_o != MAX)) begin
            count_o <= count_o + 1'b1;
        end
    end

endmodule

// File: rtl/mmu_replica_monitor.sv
// Launches a toggle into a replica delay chain and flags samples that return a cycle late;
// raises a sticky alert after ERR_THRESH consecutive late samples.
module mmu_replica_monitor
    import mmu_monitor_pkg::*;
#(
    parameter int unsigned WARMUP_CYCLES = DEF_WARMUP_CYCLES,
    parameter int unsigned ERR_THRESH    = DEF_ERR_THRESH,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             clear_i,
    output logic             launch_o,
    input  logic             replica_i,
    output logic             slow_o,
    output logic             alert_o,
    input  logic             alert_ack_i,
    output logic [CNT_W-1:0] err_count_o,
    output logic [1:0]       state_o
);

    localparam int unsigned           TH       = (ERR_THRESH < 1) ? 1 : ERR_THRESH;
    localparam int unsigned           CONS_W   = cnt_width(TH);
    localparam int unsigned           WU_W     = cnt_width(WARMUP_CYCLES);
    localparam logic [CONS_W-1:0]     CONS_MAX = CONS_W'(TH);
    localparam logic [CONS_W-1:0]     CONS_PRE = CONS_W'(TH - 1);

    logic [1:0]        state_q, state_d;
    logic [WU_W-1:0]   wu_q;
    logic [CONS_W-1:0] cons_cnt;
    logic              launch_q, cap_q, exp_q, chk_q, late_q;
    logic              mism, clean, ack;

    // Compare result for the sample held in cap_q/exp_q, evaluated on this edge.
    assign mism  = chk_q & (cap_q ^ exp_q);
    assign clean = chk_q & ~(cap_q ^ exp_q);
    assign ack   = alert_ack_i && (state_q == ST_ALERT);

    always_comb begin
        state_d = state_q;
        if (!enable_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    state_d = ST_WARMUP;
                ST_WARMUP:  if (wu_q == '0) state_d = ST_MONITOR;
                ST_MONITOR: if (mism && (cons_cnt >= CONS_PRE)) state_d = ST_ALERT;
                ST_ALERT:   if (alert_ack_i) state_d = ST_MONITOR;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            wu_q    <= '0;
        end else begin
            state_q <= state_d;
            if (!enable_i) begin
                wu_q <= '0;
            end else if (state_q == ST_IDLE) begin
                wu_q <= WU_W'(WARMUP_CYCLES);
            end else if ((state_q == ST_WARMUP) && (wu_q != '0)) begin
                wu_q <= wu_q - 1'b1;
            end
        end
    end

    // Single capture flop on replica_i is intentional: a metastable late sample is still late.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            launch_q <= 1'b0;
            cap_q    <= 1'b0;
            exp_q    <= 1'b0;
            chk_q    <= 1'b0;
            late_q   <= 1'b0;
        end else begin
            if (state_q != ST_IDLE) launch_q <= ~launch_q;
            cap_q  <= replica_i;
            exp_q  <= launch_q;
            chk_q  <= enable_i && ((state_q == ST_MONITOR) || (state_q == ST_ALERT));
            late_q <= enable_i && mism;
        end
    end

    sat_counter #(
        .WIDTH (CONS_W),
        .MAX   (CONS_MAX)
    ) u_cons_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (~enable_i | clean | ack),
        .inc_i   (mism),
        .count_o (cons_cnt)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_err_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (clear_i),
        .inc_i   (late_q),
        .count_o (err_count_o)
    );

    assign launch_o = launch_q;
    assign slow_o   = late_q;
    assign alert_o  = (state_q == ST_ALERT);
    assign state_o  = state_q;

endmodule
